// File: rtl/uop_index_gen_if.sv
// Handshake and SRAM bundle between the micro-op sequencer, uop SRAM and GEMM datapath.
`timescale 1ns/1ps
interface uop_index_gen_if #(
  parameter int UPC_WIDTH     = 13,
  parameter int ACC_IDX_WIDTH = 11,
  parameter int INP_IDX_WIDTH = 11,
  parameter int WGT_IDX_WIDTH = 10
);
  logic                     in_valid;
  logic                     in_ready;
  logic [UPC_WIDTH-1:0]     upc;
  logic [ACC_IDX_WIDTH-1:0] dst_offset_out;
  logic [ACC_IDX_WIDTH-1:0] dst_offset_in;
  logic [INP_IDX_WIDTH-1:0] src_offset_out;
  logic [INP_IDX_WIDTH-1:0] src_offset_in;
  logic [WGT_IDX_WIDTH-1:0] wgt_offset_out;
  logic [WGT_IDX_WIDTH-1:0] wgt_offset_in;
  logic                     uop_rd_en;
  logic [UPC_WIDTH-1:0]     uop_rd_addr;
  logic [31:0]              uop_rd_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [ACC_IDX_WIDTH-1:0] acc_idx;
  logic [INP_IDX_WIDTH-1:0] inp_idx;
  logic [WGT_IDX_WIDTH-1:0] wgt_idx;
  logic [31:0]              uop_cnt;
  logic                     idx_err;

  modport master (
    output in_valid, upc, dst_offset_out, dst_offset_in, src_offset_out, src_offset_in,
           wgt_offset_out, wgt_offset_in, uop_rd_data, out_ready,
    input  in_ready, uop_rd_en, uop_rd_addr, out_valid, acc_idx, inp_idx, wgt_idx,
           uop_cnt, idx_err
  );

  modport slave (
    input  in_valid, upc, dst_offset_out, dst_offset_in, src_offset_out, src_offset_in,
           wgt_offset_out, wgt_offset_in, uop_rd_data, out_ready,
    output in_ready, uop_rd_en, uop_rd_addr, out_valid, acc_idx, inp_idx, wgt_idx,
           uop_cnt, idx_err
  );
endinterface

// File: rtl/uop_index_gen.sv
// Two-stage micro-op index generator: SRAM read + offset sums, then final index register.
// Optional bounds checking of final indices is compiled in with UOP_IDX_BOUNDS_CHK_EN.
`timescale 1ns/1ps
module uop_index_gen #(
  parameter int UPC_WIDTH     = 13,
  parameter int ACC_IDX_WIDTH = 11,
  parameter int INP_IDX_WIDTH = 11,
  parameter int WGT_IDX_WIDTH = 10
`ifdef UOP_IDX_BOUNDS_CHK_EN
  ,
  parameter int ACC_DEPTH     = 2048,
  parameter int INP_DEPTH     = 2048,
  parameter int WGT_DEPTH     = 1024
`endif
) (
  input logic           clk,
  input logic           rst,
  uop_index_gen_if.slave bus
);
  localparam int AW = ACC_IDX_WIDTH;
  localparam int IW = INP_IDX_WIDTH;
  localparam int WW = WGT_IDX_WIDTH;
  localparam int WL = AW + IW;
`ifdef UOP_IDX_BOUNDS_CHK_EN
  localparam int XS = 1;
`else
  localparam int XS = 0;
`endif

  logic          a_valid;
  logic          b_valid;
  logic          hold_valid;
  logic [31:0]   hold_reg;
  logic [31:0]   rd_word;
  logic          accept;
  logic          b_adv;
  logic [AW+XS-1:0] dst_sum;
  logic [IW+XS-1:0] src_sum;
  logic [WW+XS-1:0] wgt_sum;
  logic [AW-1:0] acc_field;
  logic [IW-1:0] inp_field;
  logic [WW-1:0] wgt_field;
  logic [AW-1:0] acc_q;
  logic [IW-1:0] inp_q;
  logic [WW-1:0] wgt_q;
  logic [31:0]   cnt_q;

  assign b_adv           = a_valid && (!b_valid || bus.out_ready);
  assign bus.in_ready    = !a_valid || b_adv;
  assign accept          = bus.in_valid && bus.in_ready;
  assign bus.uop_rd_en   = accept;
  assign bus.uop_rd_addr = UPC_WIDTH'(bus.upc);

  // The SRAM word is only on the bus the cycle after the read; later it comes from hold_reg.
  assign rd_word   = hold_valid ? hold_reg : bus.uop_rd_data;
  assign acc_field = rd_word[AW-1:0];
  assign inp_field = rd_word[WL-1:AW];
  assign wgt_field = rd_word[WL+WW-1:WL];

  assign bus.out_valid = b_valid;
  assign bus.acc_idx   = acc_q;
  assign bus.inp_idx   = inp_q;
  assign bus.wgt_idx   = wgt_q;
  assign bus.uop_cnt   = cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_valid <= 1'b0;
      dst_sum <= '0;
      src_sum <= '0;
      wgt_sum <= '0;
    end else if (accept) begin
      a_valid <= 1'b1;
      dst_sum <= (AW+XS)'(bus.dst_offset_out) + (AW+XS)'(bus.dst_offset_in);
      src_sum <= (IW+XS)'(bus.src_offset_out) + (IW+XS)'(bus.src_offset_in);
      wgt_sum <= (WW+XS)'(bus.wgt_offset_out) + (WW+XS)'(bus.wgt_offset_in);
    end else if (b_adv) begin
      a_valid <= 1'b0;
    end
  end

  // A stalled entry that has no hold copy yet is exactly one cycle past its read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid <= 1'b0;
      hold_reg   <= '0;
    end else if (b_adv) begin
      hold_valid <= 1'b0;
    end else if (a_valid && !hold_valid) begin
      hold_valid <= 1'b1;
      hold_reg   <= bus.uop_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_valid <= 1'b0;
      acc_q   <= '0;
      inp_q   <= '0;
      wgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (b_adv) begin
        b_valid <= 1'b1;
        acc_q   <= acc_field + dst_sum[AW-1:0];
        inp_q   <= inp_field + src_sum[IW-1:0];
        wgt_q   <= wgt_field + wgt_sum[WW-1:0];
      end else if (bus.out_ready) begin
        b_valid <= 1'b0;
      end
      if (b_valid && bus.out_ready) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

`ifdef UOP_IDX_BOUNDS_CHK_EN
  localparam logic [AW+1:0] ACC_LIM = (AW+2)'(ACC_DEPTH);
  localparam logic [IW+1:0] INP_LIM = (IW+2)'(INP_DEPTH);
  localparam logic [WW+1:0] WGT_LIM = (WW+2)'(WGT_DEPTH);

  logic [AW+1:0] acc_full;
  logic [IW+1:0] inp_full;
  logic [WW+1:0] wgt_full;
  logic          bound_hit;
  logic          err_q;

  assign acc_full  = {2'b00, acc_field} + (AW+2)'(dst_sum);
  assign inp_full  = {2'b00, inp_field} + (IW+2)'(src_sum);
  assign wgt_full  = {2'b00, wgt_field} + (WW+2)'(wgt_sum);
  assign bound_hit = (acc_full >= ACC_LIM) || (inp_full >= INP_LIM) || (wgt_full >= WGT_LIM);
  assign bus.idx_err = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (b_adv && bound_hit) begin
      err_q <= 1'b1;
    end
  end
`else
  assign bus.idx_err = 1'b0;
`endif
endmodule

// File: tb/tb_uop_index_gen.sv
// Scoreboard bench for uop_index_gen: random stimulus against an arithmetic index model.
`timescale 1ns/1ps
module tb_uop_index_gen;
`ifdef UOP_IDX_BOUNDS_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [10:0] acc;
    logic [10:0] inp;
    logic [9:0]  wgt;
    bit          err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem [0:8191];
  exp_t        sb[$];
  int          xfer_cyc[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          exp_cnt = 0;
  bit          err_acc = 1'b0;
  int          acc_cyc = 0;

  uop_index_gen_if bus ();

  uop_index_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM word is only meaningful the cycle after a read; otherwise the bus carries junk.
  always @(posedge clk) bus.uop_rd_data <= bus.uop_rd_en ? mem[bus.uop_rd_addr] : $urandom();

  function automatic exp_t model(input logic [31:0] w, input int d_o, input int d_i,
                                 input int s_o, input int s_i, input int w_o, input int w_i);
    int   a;
    int   i;
    int   g;
    exp_t e;
    a = int'(w[10:0]) + d_o + d_i;
    i = int'(w[21:11]) + s_o + s_i;
    g = int'(w[31:22]) + w_o + w_i;
    e.acc = 11'(a % 2048);
    e.inp = 11'(i % 2048);
    e.wgt = 10'(g % 1024);
    e.err = CHK && ((a >= 2048) || (i >= 2048) || (g >= 1024));
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input bit v, input int u, input int d_o, input int d_i,
                               input int s_o, input int s_i, input int w_o, input int w_i,
                               input bit ordy, output bit acc);
    logic [12:0] ua;
    ua = 13'(u);
    bus.in_valid       = v;
    bus.upc            = ua;
    bus.dst_offset_out = 11'(d_o);
    bus.dst_offset_in  = 11'(d_i);
    bus.src_offset_out = 11'(s_o);
    bus.src_offset_in  = 11'(s_i);
    bus.wgt_offset_out = 10'(w_o);
    bus.wgt_offset_in  = 10'(w_i);
    bus.out_ready      = ordy;
    @(negedge clk);
    acc = v && bus.in_ready;
    if (v) checkOutput("rd_addr", 32'(bus.uop_rd_addr), 32'(ua));
    if (acc) begin
      sb.push_back(model(mem[ua], d_o, d_i, s_o, s_i, w_o, w_i));
      acc_cyc = cyc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit a;
    int guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b1, a);
      guard++;
    end
    checkOutput("drain_left", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every visible output must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        sb.delete();
        err_acc = 1'b0;
        exp_cnt = 0;
      end else if (bus.out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("out_unexpected", 32'(bus.out_valid), 32'd0);
        end else begin
          e = sb[0];
          checkOutput("acc_idx", 32'(bus.acc_idx), 32'(e.acc));
          checkOutput("inp_idx", 32'(bus.inp_idx), 32'(e.inp));
          checkOutput("wgt_idx", 32'(bus.wgt_idx), 32'(e.wgt));
          checkOutput("uop_cnt", bus.uop_cnt, 32'(exp_cnt));
          checkOutput("idx_err", 32'(bus.idx_err), 32'(err_acc | e.err));
          if (bus.out_ready) begin
            void'(sb.pop_front());
            err_acc = err_acc | e.err;
            exp_cnt++;
            xfer_cyc.push_back(cyc);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit a;
    int n0;
    int first_acc;
    int total;
    int guard;

    for (int k = 0; k < 8192; k++) mem[k] = $urandom();
    mem[0] = 32'h0040_1003;
    bus.in_valid = 1'b0;
    bus.upc = '0;
    bus.dst_offset_out = '0;
    bus.dst_offset_in = '0;
    bus.src_offset_out = '0;
    bus.src_offset_in = '0;
    bus.wgt_offset_out = '0;
    bus.wgt_offset_in = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_uop_cnt", bus.uop_cnt, 32'd0);
    checkOutput("rst_idx_err", 32'(bus.idx_err), 32'd0);
    checkOutput("rst_acc_idx", 32'(bus.acc_idx), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single uop with offsets");
    n0 = xfer_cyc.size();
    applyStimulus(1'b1, 0, 5, 2, 1, 1, 3, 0, 1'b1, a);
    checkOutput("t1_accept", 32'(a), 32'd1);
    first_acc = acc_cyc;
    drain();
    checkOutput("t1_count", 32'(xfer_cyc.size() - n0), 32'd1);
    if (xfer_cyc.size() > n0) checkOutput("t1_latency", 32'(xfer_cyc[n0] - first_acc), 32'd2);
    checkOutput("t1_uop_cnt", bus.uop_cnt, 32'd1);

    $display("[TB] back-to-back upc 0..7");
    n0 = xfer_cyc.size();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, k, $urandom_range(0, 2047), $urandom_range(0, 2047),
                    $urandom_range(0, 2047), $urandom_range(0, 2047),
                    $urandom_range(0, 1023), $urandom_range(0, 1023), 1'b1, a);
      checkOutput("t2_accept", 32'(a), 32'd1);
      if (k == 0) first_acc = acc_cyc;
    end
    drain();
    checkOutput("t2_count", 32'(xfer_cyc.size() - n0), 32'd8);
    if (xfer_cyc.size() >= n0 + 8) begin
      checkOutput("t2_latency", 32'(xfer_cyc[n0] - first_acc), 32'd2);
      checkOutput("t2_no_bubble", 32'(xfer_cyc[n0+7] - xfer_cyc[n0]), 32'd7);
    end
    checkOutput("t2_uop_cnt", bus.uop_cnt, 32'(exp_cnt));

    $display("[TB] backpressure with SRAM rewrite");
    applyStimulus(1'b1, 3, 1, 2, 3, 4, 5, 6, 1'b0, a);
    checkOutput("t3_accept0", 32'(a), 32'd1);
    applyStimulus(1'b1, 4, 7, 8, 9, 10, 11, 12, 1'b0, a);
    checkOutput("t3_accept1", 32'(a), 32'd1);
    mem[3] = ~mem[3];
    mem[4] = ~mem[4];
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 6, 0, 0, 0, 0, 0, 0, 1'b0, a);
      checkOutput("t3_stall", 32'(a), 32'd0);
    end
    drain();

    $display("[TB] index wrap");
    mem[5] = 32'h0000_07FF;
    applyStimulus(1'b1, 5, 1, 1, 0, 0, 0, 0, 1'b1, a);
    checkOutput("t4_accept", 32'(a), 32'd1);
    drain();
    checkOutput("t4_acc_idx", 32'(bus.acc_idx), 32'd1);
    mem[0] = 32'h0040_1003;
    applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0, 1'b1, a);
    drain();
    checkOutput("t4_err_sticky", 32'(bus.idx_err), 32'(CHK));

    $display("[TB] reset with both stages full");
    applyStimulus(1'b1, 1, 0, 0, 0, 0, 0, 0, 1'b0, a);
    applyStimulus(1'b1, 2, 0, 0, 0, 0, 0, 0, 1'b0, a);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("t5_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("t5_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("t5_uop_cnt", bus.uop_cnt, 32'd0);
    checkOutput("t5_idx_err", 32'(bus.idx_err), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b1, a);
    checkOutput("t5_no_stale", 32'(bus.out_valid), 32'd0);

    $display("[TB] random traffic, 1000 uops");
    for (int k = 0; k < 64; k++) mem[k] = $urandom();
    n0 = xfer_cyc.size();
    total = 0;
    guard = 0;
    while (total < 1000 && guard < 20000) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 63),
                    $urandom_range(0, 2047), $urandom_range(0, 2047),
                    $urandom_range(0, 2047), $urandom_range(0, 2047),
                    $urandom_range(0, 1023), $urandom_range(0, 1023),
                    $urandom_range(0, 3) != 0, a);
      if (a) total++;
      guard++;
    end
    checkOutput("t6_issued", 32'(total), 32'd1000);
    drain();
    checkOutput("t6_count", 32'(xfer_cyc.size() - n0), 32'd1000);
    checkOutput("t6_uop_cnt", bus.uop_cnt, 32'(exp_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/uop_index_gen.md
Name: uop_index_gen

Overview:
- Downstream neighbour of the micro-op sequencer in the GEMM core.
- Takes the micro-op pointer (upc) and the six loop offsets.
- Reads the 32-bit micro-op from the synchronous uop SRAM, adds the outer and inner offsets to each index field, and presents final accumulator/input/weight indices to the GEMM datapath over a valid/ready handshake.
- Two-stage pipeline with a read-data hold register, so backpressure never loses SRAM data.

Parameters:
UPC_WIDTH, 13, micro-op address width
ACC_IDX_WIDTH, 11, accumulator index width (uop bits [10:0])
INP_IDX_WIDTH, 11, input index width (uop bits [21:11])
WGT_IDX_WIDTH, 10, weight index width (uop bits [31:22])
ACC_DEPTH, 2048, accumulator entries (bounds check only)
INP_DEPTH, 2048, input buffer entries (bounds check only)
WGT_DEPTH, 1024, weight buffer entries (bounds check only)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
in_valid  in  1  upc/offsets valid
in_ready  out  1  stage accepts this cycle
upc  in  UPC_WIDTH  micro-op address
dst_offset_out  in  ACC_IDX_WIDTH  outer acc offset
dst_offset_in  in  ACC_IDX_WIDTH  inner acc offset
src_offset_out  in  INP_IDX_WIDTH  outer inp offset
src_offset_in  in  INP_IDX_WIDTH  inner inp offset
wgt_offset_out  in  WGT_IDX_WIDTH  outer wgt offset
wgt_offset_in  in  WGT_IDX_WIDTH  inner wgt offset
uop_rd_en  out  1  SRAM read strobe
uop_rd_addr  out  UPC_WIDTH  SRAM address (= upc, combinational)
uop_rd_data  in  32  SRAM data, valid 1 cycle after rd_en
out_valid  out  1  indices valid
out_ready  in  1  datapath accepts
acc_idx  out  ACC_IDX_WIDTH  final accumulator index
inp_idx  out  INP_IDX_WIDTH  final input index
wgt_idx  out  WGT_IDX_WIDTH  final weight index
uop_cnt  out  32  count of completed output transfers
idx_err  out  1  sticky bounds error (0 unless UOP_IDX_BOUNDS_CHK_EN)

Behaviour:
- Reset (async, rst=0): a_valid=0, b_valid=0, hold_valid=0, out_valid=0, acc/inp/wgt_idx=0, uop_cnt=0, idx_err=0, in_ready=1. Reset mid-operation discards all in-flight entries; no output is produced for them.
- Stage A (read issued):
  - Accept when in_valid && in_ready.
  - uop_rd_en = in_valid && in_ready.
  - Registers summed offsets: dst_sum = dst_offset_out + dst_offset_in, mod 2^ACC_IDX_WIDTH; same rule for src and wgt at their widths.
  - Sets a_valid.
- Stage B (output register):
  - b_adv = a_valid && (!b_valid || out_ready).
  - On b_adv: acc_idx = data[10:0] + dst_sum; inp_idx = data[21:11] + src_sum; wgt_idx = data[31:22] + wgt_sum. All sums are modulo their field width (wrap, no saturation).
  - data = hold_valid ? hold_reg : uop_rd_data.
- Hold register:
  - When a_valid is 1 on the first cycle after a read and b_adv=0, capture uop_rd_data into hold_reg and set hold_valid.
  - Clear hold_valid when the held entry advances to stage B.
  - SRAM data is never read more than 1 cycle after rd_en.
- in_ready = !a_valid || b_adv. Single-entry stage A; simultaneous accept and advance is allowed. Full throughput: 1 uop/cycle.
- Latency: accept at cycle N -> out_valid at N+2 when out_ready stays high.
- out_valid = b_valid. Outputs stay stable while out_valid && !out_ready.
- uop_cnt increments on each out_valid && out_ready. Wraps at 2^32.
- in_valid low: no rd_en; the pipeline drains normally.

Optional Feature:
- Macro: UOP_IDX_BOUNDS_CHK_EN.
- Defined:
  - Stage B also computes the unwrapped sums at width+2 bits.
  - Any sum >= its *_DEPTH sets idx_err on the same edge the entry loads into stage B. idx_err is sticky until reset.
  - The wrapped index is still output.
- Undefined: idx_err tied 0; no extra logic.

Test Plan:
1. Reset, uop[0]=0x00401003, upc=0, offsets dst 5+2, src 1+1, wgt 3+0, out_ready=1 -> out_valid at cycle+2 with acc_idx=10, inp_idx=4, wgt_idx=4; uop_cnt=1.
2. Back-to-back upc 0..7 with in_valid and out_ready high -> 8 consecutive out_valid cycles, in order, no bubbles; uop_cnt=8.
3. Accept upc=3, hold out_ready=0 for 5 cycles, change SRAM contents at address 3 after the read -> output equals original data + offsets, stable all 5 cycles; in_ready=0 after 2 entries are in flight.
4. Wrap: uop acc field 0x7FF, dst_offset_out=1, dst_offset_in=1 -> acc_idx=1; with UOP_IDX_BOUNDS_CHK_EN, idx_err=1 and stays 1.
5. Assert rst=0 with both stages valid and out_ready=0 -> out_valid=0, in_ready=1, uop_cnt=0 immediately; no stale output after rst release.
6. Random in_valid/out_ready toggling over 1000 uops vs reference model -> exact index sequence; no loss or duplication.
